// File: rtl/ufm_pkg.sv
// ufm_pkg: shared definitions for the UFM controller slice.
//   - UFM_DW     : UFM data word width
//   - ufm_op_e   : request operation encodings
//   - ufm_state_e: controller sequencing states
//   - op_is_legal: true for operations that reach the UFM strobes
package ufm_pkg;

    localparam int UFM_DW = 16;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_ER  = 2'b10,
        OP_RSV = 2'b11
    } ufm_op_e;

    typedef enum logic [2:0] {
        RWAIT  = 3'd0,
        IDLE   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        BLANK  = 3'd4,
        WAIT   = 3'd5,
        DONE   = 3'd6
    } ufm_state_e;

    function automatic logic op_is_legal(input ufm_op_e o);
        return o != OP_RSV;
    endfunction

endpackage

// File: rtl/ufm_if.sv
// ufm_if: parallel interface of the MAX II UFM block.
//   master modport: controller side (drives address, data in, strobes, oscena)
//   slave  modport: UFM side (drives data out, nbusy, data valid)
//   ADDR_W must match the ADDR_W of the controller it is connected to.
interface ufm_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0]          ufm_addr;
    logic [ufm_pkg::UFM_DW-1:0] ufm_di;
    logic [ufm_pkg::UFM_DW-1:0] ufm_do;
    logic                       ufm_nread;
    logic                       ufm_nwrite;
    logic                       ufm_nerase;
    logic                       ufm_nbusy;
    logic                       ufm_dvalid;
    logic                       ufm_oscena;

    modport master (
        output ufm_addr, ufm_di, ufm_nread, ufm_nwrite, ufm_nerase, ufm_oscena,
        input  ufm_do, ufm_nbusy, ufm_dvalid
    );

    modport slave (
        input  ufm_addr, ufm_di, ufm_nread, ufm_nwrite, ufm_nerase, ufm_oscena,
        output ufm_do, ufm_nbusy, ufm_dvalid
    );
endinterface

// File: rtl/ufm_rr_arb2.sv
// ufm_rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request per requester
//   take     : the grant is consumed this cycle; remember the winner
//   grant    : one-hot winner (combinational), 00 when nobody requests
// After reset the last winner is requester 1, so requester 0 wins the first tie.
module ufm_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);
    logic last_grant_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            // Contention: the requester that did not win last time goes first.
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_grant_reg <= grant[1];
        end
    end
endmodule

// File: rtl/ufm_ctrl.sv
// ufm_ctrl: sequencer and two-port arbiter in front of the UFM parallel port.
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : request per requester, held until ack
//   op[3:0]    : op[2i+1:2i] per requester (read/write/erase/reserved)
//   addr       : word address per requester, addr[ADDR_W*i +: ADDR_W]
//   wdata[31:0]: write data per requester, wdata[16i +: 16]
//   ack[1:0]   : one-cycle completion pulse to the served requester
//   err        : with ack; timeout or reserved op
//   rdata      : read result, updated only by a completed read
//   busy       : controller not in IDLE
//   ufm        : UFM parallel interface (master side)
// A reset does not abort an operation already running inside the UFM, so the
// controller comes out of reset waiting for nbusy before accepting requests.
module ufm_ctrl
    import ufm_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int STROBE_CYC = 4,
    parameter int BLANK_CYC  = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [3:0]          op,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [31:0]         wdata,
    output logic [1:0]          ack,
    output logic                err,
    output logic [UFM_DW-1:0]   rdata,
    output logic                busy,
    ufm_if.master               ufm
);
    localparam logic [7:0]  STB_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0]  BLK_LAST = 8'(BLANK_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    // Per-requester views of the packed request buses.
    ufm_op_e           op_vec    [2];
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [UFM_DW-1:0] wdata_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign op_vec[gi]    = ufm_op_e'(op[2*gi +: 2]);
        assign addr_vec[gi]  = addr[ADDR_W*gi +: ADDR_W];
        assign wdata_vec[gi] = wdata[UFM_DW*gi +: UFM_DW];
    end

    ufm_state_e        state_reg, state_next;
    logic [7:0]        cyc_cnt_reg, cyc_cnt_next;
    logic [15:0]       tmr_reg;
    ufm_op_e           op_lat_reg;
    logic [ADDR_W-1:0] addr_lat_reg;
    logic [UFM_DW-1:0] wdata_lat_reg;
    logic [1:0]        gnt_lat_reg;
    logic [UFM_DW-1:0] rdata_reg;
    logic [1:0]        ack_reg, ack_next;
    logic              err_reg, err_next;
    logic              nread_reg, nwrite_reg, nerase_reg;
    logic              rd_capture;
    logic              arb_take;
    logic              tmr_expired;
    logic [1:0]        grant;
    logic              sel;
    ufm_op_e           sel_op;

    ufm_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .take  (arb_take),
        .grant (grant)
    );

    assign sel         = grant[1];
    assign sel_op      = op_vec[sel];
    assign tmr_expired = (tmr_reg == TMO_LAST);

    always_comb begin
        state_next   = state_reg;
        cyc_cnt_next = cyc_cnt_reg;
        ack_next     = 2'b00;
        err_next     = 1'b0;
        rd_capture   = 1'b0;
        arb_take     = 1'b0;
        case (state_reg)
            RWAIT: begin
                if (ufm.ufm_nbusy || tmr_expired) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (req != 2'b00) begin
                    arb_take = 1'b1;
                    if (op_is_legal(sel_op)) begin
                        state_next = SETUP;
                    end else begin
                        // Reserved op never touches the UFM.
                        state_next = DONE;
                        ack_next   = grant;
                        err_next   = 1'b1;
                    end
                end
            end
            SETUP: begin
                cyc_cnt_next = 8'd0;
                state_next   = STROBE;
            end
            STROBE: begin
                if (cyc_cnt_reg == STB_LAST) begin
                    cyc_cnt_next = 8'd0;
                    state_next   = (BLANK_CYC == 0) ? WAIT : BLANK;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 8'd1;
                end
            end
            BLANK: begin
                // nbusy may still read high right after the strobe; ignore it here.
                if (cyc_cnt_reg == BLK_LAST) begin
                    state_next = WAIT;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 8'd1;
                end
            end
            WAIT: begin
                if (ufm.ufm_nbusy && ((op_lat_reg != OP_RD) || ufm.ufm_dvalid)) begin
                    state_next = DONE;
                    ack_next   = gnt_lat_reg;
                    rd_capture = (op_lat_reg == OP_RD);
                end else if (tmr_expired) begin
                    state_next = DONE;
                    ack_next   = gnt_lat_reg;
                    err_next   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = RWAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RWAIT;
            cyc_cnt_reg   <= 8'd0;
            tmr_reg       <= 16'd0;
            op_lat_reg    <= OP_RD;
            addr_lat_reg  <= '0;
            wdata_lat_reg <= '0;
            gnt_lat_reg   <= 2'b00;
            rdata_reg     <= '0;
            ack_reg       <= 2'b00;
            err_reg       <= 1'b0;
            nread_reg     <= 1'b1;
            nwrite_reg    <= 1'b1;
            nerase_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cyc_cnt_reg <= cyc_cnt_next;
            // One timer serves both the post-reset wait and the completion wait.
            if ((state_reg == WAIT) || (state_reg == RWAIT)) begin
                tmr_reg <= tmr_reg + 16'd1;
            end else begin
                tmr_reg <= 16'd0;
            end
            if (arb_take) begin
                op_lat_reg    <= sel_op;
                addr_lat_reg  <= addr_vec[sel];
                wdata_lat_reg <= wdata_vec[sel];
                gnt_lat_reg   <= grant;
            end
            if (rd_capture) begin
                rdata_reg <= ufm.ufm_do;
            end
            ack_reg    <= ack_next;
            err_reg    <= err_next;
            // Strobes are registered so they are glitch-free and low exactly
            // while the FSM sits in STROBE; op_lat is stable from SETUP onward.
            nread_reg  <= !((state_next == STROBE) && (op_lat_reg == OP_RD));
            nwrite_reg <= !((state_next == STROBE) && (op_lat_reg == OP_WR));
            nerase_reg <= !((state_next == STROBE) && (op_lat_reg == OP_ER));
        end
    end

    assign ack            = ack_reg;
    assign err            = err_reg;
    assign rdata          = rdata_reg;
    assign busy           = (state_reg != IDLE);
    assign ufm.ufm_addr   = addr_lat_reg;
    assign ufm.ufm_di     = wdata_lat_reg;
    assign ufm.ufm_nread  = nread_reg;
    assign ufm.ufm_nwrite = nwrite_reg;
    assign ufm.ufm_nerase = nerase_reg;
    assign ufm.ufm_oscena = 1'b1;
endmodule
